// File: rtl/tpc_pkg.sv
// Shared types and constants for the traffic phase controller family.
package tpc_pkg;

  // Controller states; the encoding matches the external phase code.
  typedef enum logic [1:0] {
    ALL_RED = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10
  } tpc_state_t;

  // External phase code driven to the system top.
  localparam logic [1:0] PH_ALLRED = 2'b00;
  localparam logic [1:0] PH_GREEN  = 2'b01;
  localparam logic [1:0] PH_YELLOW = 2'b10;

  // Width of a counter that must reach (longest duration - 1); never below one bit.
  function automatic int tpc_cnt_width(input int green_cycles,
                                       input int yellow_cycles,
                                       input int allred_cycles);
    int longest;
    int w;
    longest = green_cycles;
    if (yellow_cycles > longest) longest = yellow_cycles;
    if (allred_cycles > longest) longest = allred_cycles;
    w = $clog2(longest);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin next-index selector: finds the first set request strictly after
// rr_ptr, wrapping around, with rr_ptr itself considered last.
module rr_next_sel #(
  parameter  int NUM_DIR = 4,
  localparam int DIR_W   = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] req,
  input  logic [DIR_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [DIR_W-1:0]   next_idx
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int pos;
    valid    = 1'b0;
    next_idx = '0;
    pos      = 0;
    for (int k = NUM_DIR; k >= 1; k--) begin
      pos = (int'(rr_ptr) + k) % NUM_DIR;
      if (req[pos[DIR_W-1:0]]) begin
        valid    = 1'b1;
        next_idx = pos[DIR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Multi-direction traffic phase controller: round-robin green grants with
// programmable green/yellow/all-red durations and an emergency override.
module traffic_phase_controller #(
  parameter  int NUM_DIR       = 4,
  parameter  int GREEN_CYCLES  = 8,
  parameter  int YELLOW_CYCLES = 2,
  parameter  int ALLRED_CYCLES = 1,
  localparam int DIR_W         = $clog2(NUM_DIR)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_DIR-1:0] req,
  input  logic               emergency,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic [DIR_W-1:0]   active_dir,
  output logic [1:0]         phase
);

  import tpc_pkg::*;

  localparam int CNT_W = tpc_cnt_width(GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES);
  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYCLES - 1);

  tpc_state_t         state;
  tpc_state_t         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   cur_last;
  logic               at_last;
  logic [DIR_W-1:0]   rr_ptr;
  logic [NUM_DIR-1:0] active_mask;
  logic [NUM_DIR-1:0] other;
  logic               sel_valid;
  logic [DIR_W-1:0]   sel_idx;
  logic               grant;

  rr_next_sel #(
    .NUM_DIR(NUM_DIR)
  ) u_sel (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .valid    (sel_valid),
    .next_idx (sel_idx)
  );

  assign active_mask = {{(NUM_DIR-1){1'b0}}, 1'b1} << active_dir;
  assign other       = req & ~active_mask;

  // Exit threshold of the current state; the counter saturates there.
  always_comb begin
    cur_last = AR_LAST;
    case (state)
      GREEN:   cur_last = G_LAST;
      YELLOW:  cur_last = Y_LAST;
      default: cur_last = AR_LAST;
    endcase
  end

  assign at_last = (cnt == cur_last);

  // Next-state logic; emergency blocks grants and cuts green short.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      ALL_RED: begin
        if (at_last && !emergency && sel_valid) begin
          state_nxt = GREEN;
          grant     = 1'b1;
        end
      end
      GREEN: begin
        if (emergency || (at_last && (other != '0))) begin
          state_nxt = YELLOW;
        end
      end
      YELLOW: begin
        if (at_last) begin
          state_nxt = ALL_RED;
        end
      end
      default: state_nxt = ALL_RED;
    endcase
  end

  // Dwell counter: clears on state entry, otherwise counts up to the threshold.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (!at_last) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // State, counter and arbitration pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ALL_RED;
      cnt        <= '0;
      rr_ptr     <= DIR_W'(NUM_DIR - 1);
      active_dir <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant) begin
        rr_ptr     <= sel_idx;
        active_dir <= sel_idx;
      end
    end
  end

  // Lamp and phase decode from registered state only.
  always_comb begin
    green  = '0;
    yellow = '0;
    phase  = PH_ALLRED;
    case (state)
      GREEN: begin
        green = active_mask;
        phase = PH_GREEN;
      end
      YELLOW: begin
        yellow = active_mask;
        phase  = PH_YELLOW;
      end
      default: begin
        phase = PH_ALLRED;
      end
    endcase
  end

  assign red = ~(green | yellow);

endmodule
